// File: rtl/std_gray_counter.sv
// Up/down binary counter with a registered Gray-code twin output.
// Gray is flopped from the next-state value so it never glitches.
module std_gray_counter #(
  parameter int WIDTH = 4,
  parameter int INIT  = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_up,
  input  logic             i_down,
  output logic [WIDTH-1:0] o_bin,
  output logic [WIDTH-1:0] o_gray,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (i_clr) begin
      bin_d = INIT_V;
    end else if (i_load) begin
      bin_d = i_load_val;
    end else if (i_up && !i_down) begin
      bin_d  = bin_q + ONE_V;
      wrap_d = &bin_q;
    end else if (i_down && !i_up) begin
      bin_d  = bin_q - ONE_V;
      wrap_d = ~|bin_q;
    end
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bin_q  <= INIT_V;
      gray_q <= INIT_V ^ (INIT_V >> 1);
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign o_bin  = bin_q;
  assign o_gray = gray_q;
  assign o_wrap = wrap_q;

endmodule

// File: doc/std_gray_counter.md
STD_GRAY_COUNTER -- requirements
Module: std_gray_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning counter bit width; legal values are 1 to 32.
REQ-002 The block SHALL have parameter INIT, default 0, meaning the binary reset/clear value; it is truncated to WIDTH bits.
REQ-003 The block SHALL have port i_clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port i_clr  input  1  synchronous clear to INIT.
REQ-006 The block SHALL have port i_load  input  1  synchronous load strobe.
REQ-007 The block SHALL have port i_load_val  input  WIDTH  binary value to load.
REQ-008 The block SHALL have port i_up  input  1  increment request.
REQ-009 The block SHALL have port i_down  input  1  decrement request.
REQ-010 The block SHALL have port o_bin  output  WIDTH  registered binary count.
REQ-011 The block SHALL have port o_gray  output  WIDTH  registered Gray encoding of o_bin, driven directly from flops.
REQ-012 The block SHALL have port o_wrap  output  1  registered one-cycle pulse, asserted on a modulo wrap.

Function
REQ-013 Per-edge priority SHALL be: i_rst, then i_clr, then i_load, then i_up/i_down.
REQ-014 When i_up=1 and i_down=0, count SHALL become (count+1) mod 2^WIDTH.
REQ-015 When i_down=1 and i_up=0, count SHALL become (count-1) mod 2^WIDTH.
REQ-016 When i_up and i_down are equal and there is no clr/load/rst, count SHALL hold.
REQ-017 On the edge where i_load=1 (no rst/clr), count SHALL become i_load_val; i_up/i_down are ignored that cycle.
REQ-018 On the edge where i_clr=1 (no rst), count SHALL become INIT.
REQ-019 o_gray SHALL equal o_bin ^ (o_bin >> 1) in every cycle, with zero relative latency to o_bin.
REQ-020 o_gray SHALL be registered from the next-state binary value, not computed combinationally after the o_bin flops, so it is glitch-free for clock-domain-crossing use.
REQ-021 Latency SHALL be one cycle: a request sampled at edge N is visible on o_bin/o_gray after edge N.
REQ-022 Each single increment or decrement SHALL change exactly one bit of o_gray, including the wrap steps all-ones->0 and 0->all-ones.
REQ-023 o_wrap SHALL be 1 for exactly the cycle following an increment from 2^WIDTH-1 to 0 or a decrement from 0 to 2^WIDTH-1; it is 0 otherwise.
REQ-024 Load and clear SHALL never assert o_wrap, even if the value jumps across zero.
REQ-025 With WIDTH=1, the block SHALL toggle between 0 and 1, o_gray SHALL equal o_bin, and o_wrap SHALL pulse on every 1->0 step up and every 0->1 step down.
REQ-026 The block SHALL contain no latches and no combinational path from any input to any output.

Reset
REQ-027 While i_rst=1 at an edge, the block SHALL set o_bin=INIT, o_gray=INIT^(INIT>>1), and o_wrap=0, regardless of other inputs.
REQ-028 Reset asserted mid-count SHALL take effect on the next edge with no partial update, and counting SHALL resume on the first edge after i_rst deasserts.
REQ-029 Reset and clear values SHALL be identical; they differ only in priority.

Verification
REQ-030 The bench SHALL check: WIDTH=4, INIT=0, reset, then i_up held for 17 cycles -> o_bin goes 1..15,0,1; o_gray goes 1,3,2,6,...,8,0,1; o_wrap=1 only in the cycle o_bin=0.
REQ-031 The bench SHALL check: WIDTH=4, count=0, i_down for 1 cycle -> o_bin=15, o_gray=8, o_wrap=1 for one cycle.
REQ-032 The bench SHALL check: i_load=1 with i_load_val=9 and i_up=1 at the same time -> o_bin=9, o_gray=13, o_wrap=0.
REQ-033 The bench SHALL check: i_clr=1 with i_load=1 and INIT=5 -> o_bin=5, o_gray=7; then i_up=i_down=1 for 3 cycles -> holds at 5.
REQ-034 The bench SHALL check: i_rst asserted at count 11 with i_up=1 -> o_bin=INIT on the next edge; after deassert, one i_up -> INIT+1.
REQ-035 The bench SHALL check: a random up/down/load stream over 10k cycles at WIDTH 1, 4 and 7, asserting REQ-019 every cycle and a single-bit o_gray change on every up/down step.
